// File: rtl/apogee_tape_pkg.sv
// Shared definitions for the Apogee/RK tape player: player states, default timing
// and framing constants, and the biphase half-bit level helper.
package apogee_tape_pkg;

   localparam int unsigned DEF_HALF_TICKS   = 160;
   localparam int unsigned DEF_LEADER_BYTES = 256;
   localparam logic [7:0]  DEF_SYNC_BYTE    = 8'hE6;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LEADER = 3'd1,
      ST_SYNC   = 3'd2,
      ST_DATA   = 3'd3,
      ST_FINISH = 3'd4
   } tape_state_e;

   // Biphase cell: first half carries the inverted bit, second half the bit itself.
   function automatic logic halfLevel(input logic bitVal, input logic secondHalf);
      return secondHalf ? bitVal : ~bitVal;
   endfunction

endpackage

// File: rtl/tape_phase_timer.sv
// Half-bit timer: counts ce ticks while enabled and pulses o_half_done on the tick
// that completes a half-bit. Holding i_enable low freezes the count in place.
module tape_phase_timer
   import apogee_tape_pkg::*;
#(
   parameter int unsigned HALF_TICKS = DEF_HALF_TICKS
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_clear,
   input  logic i_enable,
   input  logic i_ce,
   output logic o_half_done
);

   localparam int unsigned CW = (HALF_TICKS > 1) ? $clog2(HALF_TICKS) : 1;
   localparam logic [CW-1:0] LAST = CW'(HALF_TICKS - 1);

   logic [CW-1:0] r_count;
   logic          w_tick;

   assign w_tick      = i_enable & i_ce;
   assign o_half_done = w_tick & (r_count == LAST);

   always_ff @(posedge i_clk) begin
      if (i_reset || i_clear) begin
         r_count <= '0;
      end else if (w_tick) begin
         r_count <= (r_count == LAST) ? '0 : r_count + 1'b1;
      end
   end

endmodule

// File: rtl/rk_tape_player.sv
// Tape playback engine: leader, sync byte, then payload fetched over a request/valid
// port, emitted as biphase on tape_out. Define TAPE_PLAYER_PAUSE_EN to add a pause input.
module rk_tape_player
   import apogee_tape_pkg::*;
#(
   parameter int unsigned HALF_TICKS   = DEF_HALF_TICKS,
   parameter int unsigned LEADER_BYTES = DEF_LEADER_BYTES,
   parameter logic [7:0]  SYNC_BYTE    = DEF_SYNC_BYTE
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        ce,
   input  logic        start,
   input  logic        stop,
   input  logic [15:0] length,
   output logic [15:0] rd_addr,
   output logic        rd_req,
   input  logic [7:0]  rd_data,
   input  logic        rd_valid,
   output logic        tape_out,
   output logic        busy,
   output logic        done,
`ifdef TAPE_PLAYER_PAUSE_EN
   output logic        underrun,
   input  logic        pause
`else
   output logic        underrun
`endif
);

   localparam logic [2:0]  S_IDLE      = ST_IDLE;
   localparam logic [2:0]  S_LEADER    = ST_LEADER;
   localparam logic [2:0]  S_SYNC      = ST_SYNC;
   localparam logic [2:0]  S_DATA      = ST_DATA;
   localparam logic [2:0]  S_FINISH    = ST_FINISH;
   localparam logic [15:0] LEADER_LAST = 16'(LEADER_BYTES - 1);

   logic [2:0]  r_state;
   logic [7:0]  r_shift;
   logic [2:0]  r_bitIdx;
   logic        r_phase;
   logic        r_tape;
   logic [15:0] r_leaderCnt;
   logic [15:0] r_nextIdx;
   logic [15:0] r_length;
   logic [7:0]  r_buf;
   logic        r_bufValid;
   logic        r_rdReq;
   logic [15:0] r_rdAddr;
   logic        r_stall;
   logic        r_done;
   logic        r_underrun;

   logic w_pause;
   logic w_halfDone;
   logic w_timerEn;
   logic w_bitEnd;
   logic w_payloadEnd;
   logic w_allSent;
   logic w_resume;
   logic w_loadData;
   logic w_moreToFetch;

`ifdef TAPE_PLAYER_PAUSE_EN
   assign w_pause = pause;
`else
   assign w_pause = 1'b0;
`endif

   assign w_timerEn     = (r_state != S_IDLE) & ~r_stall & ~w_pause;
   assign w_bitEnd      = w_halfDone & r_phase & (r_bitIdx == 3'd0) & (r_state != S_FINISH);
   assign w_payloadEnd  = w_bitEnd & ((r_state == S_SYNC) | (r_state == S_DATA));
   assign w_allSent     = (r_nextIdx == r_length);
   assign w_resume      = r_stall & r_bufValid & ~w_pause;
   assign w_loadData    = w_resume | (w_payloadEnd & ~w_allSent & r_bufValid);
   assign w_moreToFetch = ({1'b0, r_nextIdx} + 17'd1) < {1'b0, r_length};

   tape_phase_timer #(
      .HALF_TICKS(HALF_TICKS)
   ) u_timer (
      .i_clk      (clk_sys),
      .i_reset    (reset),
      .i_clear    (r_state == S_IDLE),
      .i_enable   (w_timerEn),
      .i_ce       (ce),
      .o_half_done(w_halfDone)
   );

   // Main sequencer. The prefetch buffer is filled independently of the bit stream;
   // later branches in the priority chain override it for stop and byte loads.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_shift     <= 8'h00;
         r_bitIdx    <= 3'd0;
         r_phase     <= 1'b0;
         r_tape      <= 1'b0;
         r_leaderCnt <= 16'd0;
         r_nextIdx   <= 16'd0;
         r_length    <= 16'd0;
         r_buf       <= 8'h00;
         r_bufValid  <= 1'b0;
         r_rdReq     <= 1'b0;
         r_rdAddr    <= 16'd0;
         r_stall     <= 1'b0;
         r_done      <= 1'b0;
         r_underrun  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (r_rdReq && rd_valid) begin
            r_buf      <= rd_data;
            r_bufValid <= 1'b1;
            r_rdReq    <= 1'b0;
         end

         if (r_state == S_IDLE) begin
            if (start) begin
               r_state     <= S_LEADER;
               r_length    <= length;
               r_leaderCnt <= 16'd0;
               r_nextIdx   <= 16'd0;
               r_shift     <= 8'h00;
               r_bitIdx    <= 3'd7;
               r_phase     <= 1'b0;
               r_tape      <= halfLevel(1'b0, 1'b0);
               r_underrun  <= 1'b0;
               r_bufValid  <= 1'b0;
               r_stall     <= 1'b0;
            end
         end else if (stop) begin
            r_state    <= S_IDLE;
            r_tape     <= 1'b0;
            r_rdReq    <= 1'b0;
            r_bufValid <= 1'b0;
            r_stall    <= 1'b0;
         end else if (w_loadData) begin
            r_state    <= S_DATA;
            r_shift    <= r_buf;
            r_bitIdx   <= 3'd7;
            r_phase    <= 1'b0;
            r_tape     <= halfLevel(r_buf[7], 1'b0);
            r_bufValid <= 1'b0;
            r_stall    <= 1'b0;
            r_nextIdx  <= r_nextIdx + 16'd1;
            if (w_moreToFetch) begin
               r_rdReq  <= 1'b1;
               r_rdAddr <= r_nextIdx + 16'd1;
            end
         end else if (w_payloadEnd) begin
            if (w_allSent) begin
               r_state <= S_FINISH;
               r_phase <= 1'b0;
               r_tape  <= 1'b0;
            end else begin
               r_stall    <= 1'b1;
               r_underrun <= 1'b1;
            end
         end else if (w_bitEnd) begin
            r_bitIdx <= 3'd7;
            r_phase  <= 1'b0;
            if (r_leaderCnt == LEADER_LAST) begin
               r_state <= S_SYNC;
               r_shift <= SYNC_BYTE;
               r_tape  <= halfLevel(SYNC_BYTE[7], 1'b0);
               if (r_length != 16'd0) begin
                  r_rdReq  <= 1'b1;
                  r_rdAddr <= 16'd0;
               end
            end else begin
               r_leaderCnt <= r_leaderCnt + 16'd1;
               r_shift     <= 8'h00;
               r_tape      <= halfLevel(1'b0, 1'b0);
            end
         end else if (w_halfDone) begin
            if (r_state == S_FINISH) begin
               if (r_phase) begin
                  r_state <= S_IDLE;
                  r_done  <= 1'b1;
                  r_phase <= 1'b0;
               end else begin
                  r_phase <= 1'b1;
               end
            end else if (!r_phase) begin
               r_phase <= 1'b1;
               r_tape  <= halfLevel(r_shift[7], 1'b1);
            end else begin
               r_phase  <= 1'b0;
               r_bitIdx <= r_bitIdx - 3'd1;
               r_shift  <= {r_shift[6:0], 1'b0};
               r_tape   <= halfLevel(r_shift[6], 1'b0);
            end
         end
      end
   end

   assign rd_addr  = r_rdAddr;
   assign rd_req   = r_rdReq;
   assign tape_out = r_tape;
   assign busy     = (r_state != S_IDLE);
   assign done     = r_done;
   assign underrun = r_underrun;

endmodule

// File: tb/tb_rk_tape_player.sv
// Self-checking bench for rk_tape_player: randomized playbacks compared against a
// half-bit level model built from the byte stream (leader, sync, payload, trailer).
module tb_rk_tape_player;

   localparam int HT = 4;
   localparam int LB = 2;
   localparam logic [7:0] SYNC = 8'hE6;

   logic        clk_sys = 1'b0;
   logic        reset, ce, start, stop, rd_req, rd_valid, tape_out, busy, done, underrun;
   logic [15:0] length, rd_addr;
   logic [7:0]  rd_data;
`ifdef TAPE_PLAYER_PAUSE_EN
   logic        pause = 1'b0;
`endif

   int          checkCount = 0;
   int          failCount  = 0;
   logic [7:0]  mem [16];
   logic        halves [$];

   rk_tape_player #(
      .HALF_TICKS  (HT),
      .LEADER_BYTES(LB),
      .SYNC_BYTE   (SYNC)
   ) dut (
      .clk_sys (clk_sys),
      .reset   (reset),
      .ce      (ce),
      .start   (start),
      .stop    (stop),
      .length  (length),
      .rd_addr (rd_addr),
      .rd_req  (rd_req),
      .rd_data (rd_data),
      .rd_valid(rd_valid),
      .tape_out(tape_out),
      .busy    (busy),
      .done    (done),
`ifdef TAPE_PLAYER_PAUSE_EN
      .underrun(underrun),
      .pause   (pause)
`else
      .underrun(underrun)
`endif
   );

   always #5 clk_sys = ~clk_sys;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checkCount++;
      if (got !== exp) begin
         failCount++;
         $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Expected tape as a list of half-bit levels, one entry per HT active ce ticks.
   task automatic buildHalves(input int len);
      logic [7:0] b;
      halves.delete();
      for (int j = 0; j < LB + 1 + len; j++) begin
         b = (j < LB) ? 8'h00 : (j == LB) ? SYNC : mem[j - LB - 1];
         for (int i = 7; i >= 0; i--) begin
            halves.push_back(~b[i]);
            halves.push_back(b[i]);
         end
      end
      halves.push_back(1'b0);
      halves.push_back(1'b0);
   endtask

   task automatic checkIdleOutputs(input string tag);
      checkOutput({tag, "_tape"}, tape_out, 0);
      checkOutput({tag, "_busy"}, busy, 0);
      checkOutput({tag, "_done"}, done, 0);
      checkOutput({tag, "_rdreq"}, rd_req, 0);
      checkOutput({tag, "_rdaddr"}, rd_addr, 0);
      checkOutput({tag, "_underrun"}, underrun, 0);
   endtask

   task automatic applyStimulus(input int len, input int cePct, input int stallByte,
                                input int stallDelay, input int stopTick,
                                input int restartTick, input int pauseTick, input int pauseTicks);
      int  n, total, delay, reqCount, respIdx, waitByte, pausedTicks, k, idx;
      bit  frozen, resumeNext, pending, finished, restarted, underrunExp;
      bit  delivered [16];
      logic ceE, vE, stopE, pauseE;
      buildHalves(len);
      total = halves.size();
      n = 0; delay = 0; reqCount = 0; respIdx = 0; waitByte = -1; pausedTicks = 0;
      frozen = 0; resumeNext = 0; pending = 0; finished = 0; restarted = 0; underrunExp = 0;
      for (int i = 0; i < 16; i++) delivered[i] = 0;
      start = 1'b1; length = 16'(len); ce = 1'b1;
      @(posedge clk_sys); #1;
      start = 1'b0;
      checkOutput("busy_on_start", busy, 1);
      checkOutput("tape_first_half", tape_out, halves[0]);
      ce = ($urandom_range(1, 100) <= cePct);
      for (int cyc = 0; cyc < 20000 && !finished; cyc++) begin
         @(posedge clk_sys);
         ceE = ce; vE = rd_valid; stopE = stop;
`ifdef TAPE_PLAYER_PAUSE_EN
         pauseE = pause;
`else
         pauseE = 1'b0;
`endif
         if (!pauseE) begin
            if (frozen) begin
               if (resumeNext) begin
                  frozen = 0;
                  resumeNext = 0;
               end
            end else if (ceE) begin
               n++;
               if (n % (16 * HT) == 0) begin
                  k = n / (16 * HT) - (LB + 1);
                  if (k >= 0 && k < len && !delivered[k]) begin
                     frozen = 1;
                     waitByte = k;
                     underrunExp = 1;
                  end
               end
            end
         end else if (ceE) begin
            pausedTicks++;
         end
         if (vE) begin
            delivered[respIdx] = 1;
            if (frozen && waitByte == respIdx) resumeNext = 1;
         end
         #1;
         start = 1'b0; stop = 1'b0; length = 16'(len);
         if (stopE) begin
            rd_valid = 1'b0;
            checkOutput("stop_busy", busy, 0);
            checkOutput("stop_tape", tape_out, 0);
            checkOutput("stop_rdreq", rd_req, 0);
            checkOutput("stop_done", done, 0);
            for (int i = 0; i < 8; i++) begin
               @(posedge clk_sys); #1;
               checkOutput("after_stop_done", done, 0);
               checkOutput("after_stop_busy", busy, 0);
            end
            return;
         end
         if (n == HT * total) begin
            finished = 1;
            checkOutput("done_pulse", done, 1);
            checkOutput("end_busy", busy, 0);
            checkOutput("end_tape", tape_out, 0);
            checkOutput("end_underrun", underrun, underrunExp);
            checkOutput("req_count", reqCount, len);
         end else begin
            idx = frozen ? n / HT - 1 : n / HT;
            checkOutput("tape", tape_out, halves[idx]);
            checkOutput("busy", busy, 1);
            checkOutput("done_early", done, 0);
            rd_valid = 1'b0;
            if (rd_req && !pending) begin
               checkOutput("rd_addr", rd_addr, reqCount);
               pending = 1;
               respIdx = reqCount;
               delay = (reqCount == stallByte) ? stallDelay : $urandom_range(1, 6);
               reqCount++;
            end
            if (pending) begin
               delay--;
               if (delay == 0) begin
                  rd_valid = 1'b1;
                  rd_data = mem[respIdx];
                  pending = 0;
               end
            end
            if (stopTick >= 0 && n == stopTick) stop = 1'b1;
            if (restartTick >= 0 && n >= restartTick && !restarted) begin
               restarted = 1;
               start = 1'b1;
               length = 16'(len + 3);
            end
`ifdef TAPE_PLAYER_PAUSE_EN
            pause = (pauseTick >= 0 && n >= pauseTick && pausedTicks < pauseTicks);
`else
            if (pauseTick >= 0 && pauseTicks > 0) checkOutput("pause_unsupported", 0, 1);
`endif
            ce = ($urandom_range(1, 100) <= cePct);
         end
      end
      rd_valid = 1'b0;
      if (!finished) checkOutput("timeout", 0, 1);
      @(posedge clk_sys); #1;
      checkOutput("done_one_cycle", done, 0);
   endtask

   initial begin
      int len;
      reset = 1'b1; ce = 1'b0; start = 1'b0; stop = 1'b0; length = 16'd0;
      rd_data = 8'h00; rd_valid = 1'b0;
      repeat (3) @(posedge clk_sys);
      #1;
      checkIdleOutputs("reset");
      reset = 1'b0;

      mem[0] = 8'hA5;
      applyStimulus(1, 100, -1, 0, -1, -1, -1, 0);
      applyStimulus(0, 100, -1, 0, -1, -1, -1, 0);

      for (int r = 0; r < 6; r++) begin
         len = $urandom_range(1, 5);
         for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
         applyStimulus(len, $urandom_range(30, 100), -1, 0, -1, -1, -1, 0);
      end

      for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
      applyStimulus(3, 100, 1, 200, -1, -1, -1, 0);
      applyStimulus(2, 100, 1, 200, (LB + 1) * 16 * HT + 3 * 2 * HT + 1, -1, -1, 0);
      applyStimulus(2, 100, -1, 0, -1, 30, -1, 0);

      start = 1'b1; length = 16'd3; ce = 1'b1;
      @(posedge clk_sys); #1;
      start = 1'b0;
      repeat (LB * 16 * HT + 10) @(posedge clk_sys);
      #1;
      checkOutput("sync_rdreq", rd_req, 1);
      checkOutput("sync_busy", busy, 1);
      reset = 1'b1;
      @(posedge clk_sys); #1;
      reset = 1'b0;
      checkIdleOutputs("midreset");
      rd_valid = 1'b1; rd_data = 8'h3C;
      @(posedge clk_sys); #1;
      rd_valid = 1'b0;
      checkOutput("late_valid_rdreq", rd_req, 0);
      checkOutput("late_valid_busy", busy, 0);
      mem[0] = 8'h5A;
      applyStimulus(1, 100, -1, 0, -1, -1, -1, 0);

`ifdef TAPE_PLAYER_PAUSE_EN
      mem[0] = 8'hC3;
      applyStimulus(1, 100, -1, 0, -1, -1, 100, 50);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
